// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, derived totals and pixel types for the
// VGA controller and the renderer that feeds it.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Both counters are 10 bits wide; totals above 1023 are not supported.
  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic cnt_t to_cnt(input int value);
    return cnt_t'(value);
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical position counters with undelayed sync and
// visible-area decode.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic pclk,
  input  logic rst,
  output cnt_t h_cnt,
  output cnt_t v_cnt,
  output logic valid,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic frame_end
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_MAX      = to_cnt(HT - 1);
  localparam cnt_t V_MAX      = to_cnt(VT - 1);
  localparam cnt_t H_VIS      = to_cnt(H_ACTIVE);
  localparam cnt_t V_VIS      = to_cnt(V_ACTIVE);
  localparam cnt_t HS_START   = to_cnt(H_ACTIVE + H_FP);
  localparam cnt_t HS_END     = to_cnt(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START   = to_cnt(V_ACTIVE + V_FP);
  localparam cnt_t VS_END     = to_cnt(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t CNT_ONE    = to_cnt(1);

  logic h_last;
  logic v_last;

  assign h_last = (h_cnt == H_MAX);
  assign v_last = (v_cnt == V_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + CNT_ONE;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + CNT_ONE;
      end
    end
  end

  assign valid     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vsync_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign frame_end = h_last && v_last;

endmodule

// File: rtl/vga_controller.sv
// VGA timing controller: counters from vga_sync_gen, one-pclk alignment of
// sync/valid with the renderer's registered pixel, blanking and frame tick.
module vga_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] vga_data,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        VGAvalid,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_tick
);

  logic valid_raw;
  logic hsync_raw;
  logic vsync_raw;
  logic frame_end;
  logic valid_d;
  rgb_t pix;

  vga_sync_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_gen (
    .pclk      (pclk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .valid     (valid_raw),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .frame_end (frame_end)
  );

  assign VGAvalid = valid_raw;

  // Sync and valid are delayed one pclk to line up with vga_data, which the
  // renderer registers one cycle after the counters; the pixel register then
  // adds the second cycle of latency to the pins.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      valid_d    <= 1'b0;
      pix        <= '0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= hsync_raw;
      vsync      <= vsync_raw;
      valid_d    <= valid_raw;
      pix        <= valid_d ? rgb_t'(vga_data) : '0;
      frame_tick <= frame_end;
    end
  end

  assign vga_r = pix.r;
  assign vga_g = pix.g;
  assign vga_b = pix.b;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: a default 640x480 instance and a shrunken-timing
// instance, both checked every cycle against a cycle-count arithmetic model.
module tb_vga_controller;

  typedef struct {
    int ha, hfp, hs, hbp;
    int va, vfp, vs, vbp;
  } tim_t;

  logic        pclk = 1'b0;
  logic        rst  = 1'b0;
  logic        checking = 1'b0;
  int          n = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          ticks_b = 0;
  tim_t        ta, tb;

  logic [11:0] data_a = '0, data_b = '0;
  logic [9:0]  h_a, v_a, h_b, v_b;
  logic        val_a, val_b, hs_a, hs_b, vs_a, vs_b, ft_a, ft_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  always #5 pclk = ~pclk;

  vga_controller u_a (
    .pclk(pclk), .rst(rst), .vga_data(data_a), .h_cnt(h_a), .v_cnt(v_a),
    .VGAvalid(val_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
  );

  vga_controller #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .pclk(pclk), .rst(rst), .vga_data(data_b), .h_cnt(h_b), .v_cnt(v_b),
    .VGAvalid(val_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
  );

  // Model: position after k pclk edges since reset release is pure arithmetic.
  function automatic int htot(input tim_t t);
    return t.ha + t.hfp + t.hs + t.hbp;
  endfunction
  function automatic int vtot(input tim_t t);
    return t.va + t.vfp + t.vs + t.vbp;
  endfunction
  function automatic int hp(input tim_t t, input int k);
    return k % htot(t);
  endfunction
  function automatic int vp(input tim_t t, input int k);
    return (k / htot(t)) % vtot(t);
  endfunction
  function automatic bit vis(input tim_t t, input int k);
    return (hp(t, k) < t.ha) && (vp(t, k) < t.va);
  endfunction
  function automatic bit hs_low(input tim_t t, input int k);
    return (hp(t, k) >= t.ha + t.hfp) && (hp(t, k) < t.ha + t.hfp + t.hs);
  endfunction
  function automatic bit vs_low(input tim_t t, input int k);
    return (vp(t, k) >= t.va + t.vfp) && (vp(t, k) < t.va + t.vfp + t.vs);
  endfunction

  // Renderer colour for the position reached after k edges.
  function automatic logic [11:0] pix(input tim_t t, input int k);
    logic [9:0] hb, vb;
    if (k < 0) return 12'h000;
    if (k < 1000) return 12'hF0F;
    hb = 10'(hp(t, k));
    vb = 10'(vp(t, k));
    return {hb[3:0] ^ vb[3:0], hb[7:4], vb[3:0] ^ 4'hA};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  task automatic compare(input string tag, input tim_t t, input int k,
                         input logic [9:0] h, input logic [9:0] v, input logic val,
                         input logic hs, input logic vs, input logic [11:0] rgb,
                         input logic ft);
    logic [11:0] exp_rgb;
    logic        exp_ft;
    exp_rgb = (k >= 2 && vis(t, k - 2)) ? pix(t, k - 2) : 12'h000;
    exp_ft  = (k >= 1) && (hp(t, k - 1) == htot(t) - 1) && (vp(t, k - 1) == vtot(t) - 1);
    check({tag, ".h_cnt"},      32'(h),   32'(hp(t, k)));
    check({tag, ".v_cnt"},      32'(v),   32'(vp(t, k)));
    check({tag, ".VGAvalid"},   32'(val), 32'(vis(t, k)));
    check({tag, ".hsync"},      32'(hs),  32'((k >= 1) ? !hs_low(t, k - 1) : 1'b1));
    check({tag, ".vsync"},      32'(vs),  32'((k >= 1) ? !vs_low(t, k - 1) : 1'b1));
    check({tag, ".rgb"},        32'(rgb), 32'(exp_rgb));
    check({tag, ".frame_tick"}, 32'(ft),  32'(exp_ft));
  endtask

  // Renderer stand-in: count edges, then present the colour one pclk late.
  always @(posedge pclk) begin
    if (rst) n = n + 1;
    #1;
    data_a = pix(ta, n - 1);
    data_b = pix(tb, n - 1);
  end

  always @(negedge pclk) begin
    if (checking) begin
      compare("A", ta, n, h_a, v_a, val_a, hs_a, vs_a, {r_a, g_a, b_a}, ft_a);
      compare("B", tb, n, h_b, v_b, val_b, hs_b, vs_b, {r_b, g_b, b_b}, ft_b);
      if (ft_b) ticks_b++;
      // Hand-computed anchors for the default 640x480 timing.
      if (n == 656)  check("A.lit_hsync_656",  32'(hs_a), 32'd1);
      if (n == 657)  check("A.lit_hsync_657",  32'(hs_a), 32'd0);
      if (n == 752)  check("A.lit_hsync_752",  32'(hs_a), 32'd0);
      if (n == 753)  check("A.lit_hsync_753",  32'(hs_a), 32'd1);
      if (n == 1457) check("A.lit_hsync_1457", 32'(hs_a), 32'd0);
      if (n == 639)  check("A.lit_valid_639",  32'(val_a), 32'd1);
      if (n == 640)  check("A.lit_valid_640",  32'(val_a), 32'd0);
      if (n == 2)    check("A.lit_rgb_first",  32'({r_a, g_a, b_a}), 32'h0F0F);
      if (n == 641)  check("A.lit_rgb_639",    32'({r_a, g_a, b_a}), 32'h0F0F);
      if (n == 642)  check("A.lit_rgb_640",    32'({r_a, g_a, b_a}), 32'h0000);
      if (n == 799)  check("A.lit_h_799",      32'(h_a), 32'd799);
      if (n == 800)  check("A.lit_wrap",       32'({v_a, h_a}), 32'({10'd1, 10'd0}));
      // Anchors for the 25x19 instance (475 pclk per frame, vsync lines 14..15).
      if (n == 474)  check("B.lit_tick_474",   32'(ft_b), 32'd0);
      if (n == 475)  check("B.lit_tick_475",   32'({ft_b, v_b, h_b}), 32'({1'b1, 20'd0}));
      if (n == 350)  check("B.lit_vsync_350",  32'(vs_b), 32'd1);
      if (n == 351)  check("B.lit_vsync_351",  32'(vs_b), 32'd0);
      if (n == 400)  check("B.lit_vsync_400",  32'(vs_b), 32'd0);
      if (n == 401)  check("B.lit_vsync_401",  32'(vs_b), 32'd1);
      if (n == 290)  check("B.lit_valid_15_11", 32'(val_b), 32'd1);
      if (n == 291)  check("B.lit_valid_16_11", 32'(val_b), 32'd0);
      if (n == 300)  check("B.lit_valid_0_12",  32'(val_b), 32'd0);
      if (n == 474)  check("B.lit_valid_24_18", 32'(val_b), 32'd0);
    end
  end

  initial begin
    int guard;
    ta = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2, vbp: 33};
    tb = '{ha: 16,  hfp: 2,  hs: 4,  hbp: 3,  va: 12,  vfp: 2,  vs: 2, vbp: 3};
    checking = 1'b1;

    repeat (3) @(negedge pclk);
    #2 rst = 1'b1;
    repeat (3000) @(posedge pclk);
    @(negedge pclk);
    check("B.frame_count", 32'(ticks_b), 32'd6);

    // Land the small instance inside its sync pulses, then reset between edges.
    guard = 0;
    while ((n % 475) != 369 && guard < 1000) begin
      @(negedge pclk);
      guard++;
    end
    check("reset_point_reached", 32'(guard < 1000), 32'd1);
    check("B.pre_reset_sync", 32'({hs_b, vs_b}), 32'd0);
    #2;
    rst = 1'b0;
    n = 0;
    #1;
    check("A.async_reset", 32'({h_a, v_a, hs_a, vs_a, r_a, g_a, b_a, ft_a}),
          32'({10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0}));
    check("B.async_reset", 32'({h_b, v_b, hs_b, vs_b, r_b, g_b, b_b, ft_b}),
          32'({10'd0, 10'd0, 1'b1, 1'b1, 12'h000, 1'b0}));

    repeat (2) @(negedge pclk);
    #2 rst = 1'b1;
    repeat (1200) @(posedge pclk);
    @(negedge pclk);
    #1 checking = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
